// File: rtl/serial_32_w_pkg.sv
// rtl/serial_32_w_pkg.sv - shared types, constants and CRC step for the 32-word serial link
package serial_32_w_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        GAP   = 3'd4
    } tx_state_e;

    localparam logic [15:0] CRC_INIT  = 16'hFFFF;
    localparam logic [15:0] CRC_POLY  = 16'hA001;
    localparam logic        LINE_IDLE = 1'b1;

    // One bit of the reflected CRC-16/Modbus-RTU shift register.
    function automatic logic [15:0] crc16_bit_step(input logic [15:0] crc, input logic din);
        logic [15:0] s;
        s = {1'b0, crc[15:1]};
        if (crc[0] ^ din) begin
            s = s ^ CRC_POLY;
        end
        return s;
    endfunction

endpackage

// File: rtl/serial_transmitter_main_32_w_crc.sv
// rtl/serial_transmitter_main_32_w_crc.sv - bit-serial CRC-16/Modbus-RTU for the transmit side
//
// Ports:
//   clk     system clock
//   reset   asynchronous active-low reset (register returns to CRC_INIT)
//   clear   synchronous re-initialise to CRC_INIT (wins over enable)
//   enable  advance the CRC by one bit using din
//   din     data bit being transmitted in the current bit slot
//   crc     current CRC register value
module crc_16_rtu_tx_32_w
    import serial_32_w_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        din,
    output logic [15:0] crc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc <= CRC_INIT;
        end else if (clear) begin
            crc <= CRC_INIT;
        end else if (enable) begin
            crc <= crc16_bit_step(crc, din);
        end
    end

endmodule

// File: rtl/serial_transmitter_main_32_w.sv
// rtl/serial_transmitter_main_32_w.sv - framing UART-style transmitter with CRC-16/Modbus and idle gap
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-low reset
//   data_in        N_WORD 16-bit words, word k on bits [16k+15:16k]
//   start          packet request, sampled only in IDLE (level-sensitive)
//   tx             serial line, idles high, driven from a flop
//   busy           high from the cycle after start is accepted until the gap ends
//   transmit_done  one-cycle pulse on the final gap cycle
//   frames_sent    (only with SERIAL_TX_FRAME_CNT_EN) wrapping count of transmit_done pulses
//
// Optional feature macro: SERIAL_TX_FRAME_CNT_EN
module serial_transmitter_main_32_w
    import serial_32_w_pkg::*;
#(
    parameter int N_WORD      = 32,
    parameter int CLK_PER_BIT = 4,
    parameter int GAP_BITS    = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [16*N_WORD-1:0]  data_in,
    input  logic                  start,
    output logic                  tx,
    output logic                  busy,
    output logic                  transmit_done
`ifdef SERIAL_TX_FRAME_CNT_EN
    ,
    output logic [15:0]           frames_sent
`endif
);

    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int GW = $clog2(GAP_BITS + 1);

    localparam logic [CW-1:0] BIT_LAST   = CW'(CLK_PER_BIT - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_BITS - 1);
    localparam logic [6:0]    DATA_BYTES = 7'(2 * N_WORD);
    localparam logic [6:0]    LAST_BYTE  = 7'(2 * N_WORD + 1);

    tx_state_e             state_q,    state_n;
    logic [CW-1:0]         bit_cnt_q,  bit_cnt_n;
    logic [2:0]            bit_idx_q,  bit_idx_n;
    logic [6:0]            byte_idx_q, byte_idx_n;
    logic [GW-1:0]         gap_cnt_q,  gap_cnt_n;
    logic [16*N_WORD-1:0]  shadow_q;
    logic                  tx_q, tx_n;
    logic                  load;
    logic                  crc_clear;
    logic                  crc_en;
    logic [15:0]           crc;
    logic                  bit_end;
    logic [15:0]           word_n;
    logic [7:0]            byte_n;

    assign bit_end = (bit_cnt_q == BIT_LAST);

    // Next-state and counter logic.
    always_comb begin
        state_n    = state_q;
        bit_cnt_n  = bit_cnt_q;
        bit_idx_n  = bit_idx_q;
        byte_idx_n = byte_idx_q;
        gap_cnt_n  = gap_cnt_q;
        load       = 1'b0;
        crc_clear  = 1'b0;

        if (state_q != IDLE) begin
            bit_cnt_n = bit_end ? '0 : bit_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_n    = START;
                    bit_cnt_n  = '0;
                    bit_idx_n  = '0;
                    byte_idx_n = '0;
                    gap_cnt_n  = '0;
                    load       = 1'b1;
                    crc_clear  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_idx_q == LAST_BYTE) begin
                        state_n   = GAP;
                        gap_cnt_n = '0;
                    end else begin
                        state_n    = START;
                        byte_idx_n = byte_idx_q + 7'd1;
                    end
                end
            end
            GAP: begin
                if (bit_end) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_n = IDLE;
                    end else begin
                        gap_cnt_n = gap_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Byte to be on the line in the next cycle. Data bytes come from the
    // shadow copy, high byte of each word first; then CRC low, CRC high.
    // The CRC is already final when the first CRC byte is selected because
    // the last data bit updates it on entry to that byte's STOP.
    always_comb begin
        word_n = '0;
        byte_n = crc[15:8];
        if (byte_idx_n < DATA_BYTES) begin
            for (int k = 0; k < N_WORD; k++) begin
                if (byte_idx_n[6:1] == 6'(k)) begin
                    word_n = shadow_q[16*k +: 16];
                end
            end
            byte_n = byte_idx_n[0] ? word_n[7:0] : word_n[15:8];
        end else if (byte_idx_n == DATA_BYTES) begin
            byte_n = crc[7:0];
        end
    end

    // tx is precomputed from the next state so the pin comes straight off a flop.
    always_comb begin
        tx_n = LINE_IDLE;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = byte_n[bit_idx_n];
            default: tx_n = LINE_IDLE;
        endcase
    end

    // tx_q holds the bit of the current slot, so it is also the CRC input.
    assign crc_en = (state_q == DATA) && bit_end && (byte_idx_q < DATA_BYTES);

    crc_16_rtu_tx_32_w u_crc (
        .clk    (clk),
        .reset  (reset),
        .clear  (crc_clear),
        .enable (crc_en),
        .din    (tx_q),
        .crc    (crc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            gap_cnt_q  <= '0;
            shadow_q   <= '0;
            tx_q       <= LINE_IDLE;
        end else begin
            state_q    <= state_n;
            bit_cnt_q  <= bit_cnt_n;
            bit_idx_q  <= bit_idx_n;
            byte_idx_q <= byte_idx_n;
            gap_cnt_q  <= gap_cnt_n;
            tx_q       <= tx_n;
            if (load) begin
                shadow_q <= data_in;
            end
        end
    end

    assign tx            = tx_q;
    assign busy          = (state_q != IDLE);
    assign transmit_done = (state_q == GAP) && bit_end && (gap_cnt_q == GAP_LAST);

`ifdef SERIAL_TX_FRAME_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frames_sent <= '0;
        end else if (transmit_done) begin
            frames_sent <= frames_sent + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_serial_transmitter_main_32_w.sv
// tb/tb_serial_transmitter_main_32_w.sv - scoreboard bench for serial_transmitter_main_32_w
module tb_serial_transmitter_main_32_w;

    localparam int NW        = 3;
    localparam int CPB       = 4;
    localparam int GB        = 12;
    localparam int FRAME_CYC = (2 * NW + 2) * 10 * CPB + GB * CPB;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [16*NW-1:0]   data_in = '0;
    logic               tx;
    logic               busy;
    logic               transmit_done;
`ifdef SERIAL_TX_FRAME_CNT_EN
    logic [15:0]        frames_sent;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int done_cnt = 0;
    int done_since_reset = 0;

    always #5 clk = ~clk;

    serial_transmitter_main_32_w #(
        .N_WORD      (NW),
        .CLK_PER_BIT (CPB),
        .GAP_BITS    (GB)
    ) dut (
        .clk           (clk),
        .reset         (rst_n),
        .data_in       (data_in),
        .start         (start),
        .tx            (tx),
        .busy          (busy),
        .transmit_done (transmit_done)
`ifdef SERIAL_TX_FRAME_CNT_EN
        ,
        .frames_sent   (frames_sent)
`endif
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endfunction

    // Textbook byte-wise Modbus CRC over the packet payload.
    function automatic logic [15:0] model_crc(input logic [7:0] bytes[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (bytes[i]) begin
            c = c ^ {8'h00, bytes[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
            end
        end
        return c;
    endfunction

    task automatic push_frame(input logic [16*NW-1:0] d);
        logic [7:0]  bytes[$];
        logic [15:0] w;
        logic [15:0] c;
        for (int k = 0; k < NW; k++) begin
            w = d[16*k +: 16];
            bytes.push_back(w[15:8]);
            bytes.push_back(w[7:0]);
        end
        c = model_crc(bytes);
        foreach (bytes[i]) exp_q.push_back(bytes[i]);
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
    endtask

    task automatic send_raw(input logic [16*NW-1:0] d);
        @(posedge clk);
        #1;
        data_in = d;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [16*NW-1:0] d);
        push_frame(d);
        send_raw(d);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (transmit_done !== 1'b1 && n < 3 * FRAME_CYC);
        check({name, "_done_seen"}, transmit_done, 1'b1);
    endtask

    function automatic logic [16*NW-1:0] rand_data();
        logic [16*NW-1:0] d;
        for (int k = 0; k < NW; k++) d[16*k +: 16] = 16'($urandom);
        return d;
    endfunction

    // UART decoder / scoreboard consumer: cycle 0 is the first low tx cycle
    // of a byte; bits are sampled mid-slot.
    initial begin : decoder
        bit         active;
        int         cnt;
        logic [7:0] rx;
        logic [7:0] e;
        active = 1'b0;
        cnt    = 0;
        rx     = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    active = 1'b1;
                    cnt    = 0;
                end
            end else begin
                cnt++;
                if (cnt == CPB / 2) begin
                    check("start_bit", tx, 1'b0);
                end else if (cnt >= CPB + CPB / 2 && cnt < 9 * CPB && ((cnt - CPB / 2) % CPB) == 0) begin
                    rx[(cnt - CPB / 2) / CPB - 1] = tx;
                end else if (cnt == 9 * CPB + CPB / 2) begin
                    check("stop_bit", tx, 1'b1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", rx, 8'hxx);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", rx, e);
                    end
                    active = 1'b0;
                end
            end
        end
    end

    // Frame timing: transmit_done lands FRAME_CYC cycles after busy rises,
    // and busy drops on the following cycle.
    initial begin : timing_mon
        int  busy_cyc;
        bit  prev_done;
        busy_cyc  = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cyc         = 0;
                prev_done        = 1'b0;
                done_since_reset = 0;
            end else begin
                if (prev_done) check("busy_after_done", busy, 1'b0);
                if (busy === 1'b1) busy_cyc++;
                if (transmit_done === 1'b1) begin
                    check("done_latency", busy_cyc, FRAME_CYC);
                    done_cnt++;
                    done_since_reset++;
                    busy_cyc = 0;
                end
                prev_done = (transmit_done === 1'b1);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [16*NW-1:0] d;
        int d0;

        // Reset state
        #2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_done", transmit_done, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        check("idle_tx", tx, 1'b1);

        // Known-CRC frame with constant expected bytes
        exp_q.push_back(8'h01); exp_q.push_back(8'h03);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        exp_q.push_back(8'h84); exp_q.push_back(8'h0A);
        send_raw({16'h0001, 16'h0000, 16'h0103});
        wait_done("known_crc");
        check("known_crc_all_bytes", exp_q.size(), 0);

        // Randomized frames against the reference model
        for (int i = 0; i < 6; i++) begin
            send(rand_data());
            wait_done("random");
            check("random_all_bytes", exp_q.size(), 0);
        end

        // data_in changes while busy must not affect the packet
        send({NW{16'hAAAA}});
        repeat (100) @(posedge clk);
        #1;
        data_in = {NW{16'h5555}};
        wait_done("shadow");
        check("shadow_all_bytes", exp_q.size(), 0);

        // start held high: three back-to-back frames
        d  = rand_data();
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) push_frame(d);
        @(posedge clk);
        #1;
        data_in = d;
        start   = 1'b1;
        for (int i = 0; i < 3; i++) wait_done("b2b");
        start = 1'b0;
        check("b2b_pulses", done_cnt - d0, 3);
        repeat (4) @(negedge clk);
        check("b2b_all_bytes", exp_q.size(), 0);
        check("b2b_stopped", busy, 1'b0);

        // Asynchronous reset in the middle of byte 5's data bits
        send(rand_data());
        repeat (5 * 10 * CPB + 15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_tx", tx, 1'b1);
        check("abort_busy", busy, 1'b0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(rand_data());
        wait_done("after_abort");
        check("after_abort_all_bytes", exp_q.size(), 0);

`ifdef SERIAL_TX_FRAME_CNT_EN
        @(negedge clk);
        check("frames_sent", frames_sent, 16'(done_since_reset));
`endif

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_transmitter_main_32_w.md
Name: serial_transmitter_main_32_w

Overview:
- Framing transmitter for the 32-word serial link; the far-end receiver decodes its output.
- Latches up to N_WORD 16-bit words on a start strobe and serialises them as UART-style bytes.
- Appends a CRC-16/Modbus-RTU and a fixed idle gap, so the receiver's timeout logic frames the packet.
- Sits at the FPGA top level, driving the tx pin from the vector-control data path.

Parameters:
- N_WORD, 32, number of 16-bit words per packet (1..32).
- CLK_PER_BIT, 4, clk cycles per line bit (>=2); 4 matches the receiver's clk/4 sampling.
- GAP_BITS, 12, idle-high bit times after the CRC; packet = 20*N_WORD + 20 + GAP_BITS bits.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  16*N_WORD  word k on bits [16k+15:16k].
- start  input  1  request; sampled only in IDLE.
- tx  output  1  serial line, idles high.
- busy  output  1  high from the cycle after start is accepted until the last gap bit ends.
- transmit_done  output  1  one-cycle pulse at the end of the gap.

Behaviour:
- Reset (async assert, sync release): tx=1, busy=0, transmit_done=0, state IDLE, all counters 0, CRC register 0xFFFF.
- Reset mid-packet aborts immediately; tx returns high with no partial stop bit.
- IDLE: if start=1, the whole data_in is captured into a shadow register the same cycle.
  - Next cycle: busy=1, byte index=0, CRC=0xFFFF, state START.
  - start is level-sensitive: held high gives back-to-back packets, one IDLE cycle between them.
- Byte order:
  - Word 0 first; within each word, high byte first.
  - Then CRC low byte, then CRC high byte.
  - Bytes total = 2*N_WORD + 2.
- Byte frame:
  - START: tx=0 for CLK_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each CLK_PER_BIT cycles.
  - STOP: tx=1 for CLK_PER_BIT cycles.
  - No inter-byte gap.
- CRC:
  - Reflected polynomial 0xA001, init 0xFFFF, updated one bit per bit slot with the data bit being sent.
  - CRC bytes are not fed back into the CRC.
  - The CRC value is frozen when the last data byte's STOP begins.
- GAP: tx=1 for GAP_BITS*CLK_PER_BIT cycles.
  - On the final gap cycle, transmit_done=1.
  - Next cycle: busy=0, state IDLE.
- State sequence: IDLE -> START -> DATA -> STOP.
  - From STOP: back to START if more bytes remain, else GAP.
  - GAP -> IDLE.
- Counters:
  - Bit-time counter is ceil(log2(CLK_PER_BIT)) wide and wraps at CLK_PER_BIT-1.
  - Bit index is 3 bits; byte index is 7 bits.
- data_in changes while busy have no effect on the current packet.
- tx is driven directly from a flop (glitch-free); tx is never X after reset.

Optional Feature:
- Macro SERIAL_TX_FRAME_CNT_EN.
- When defined: adds output frames_sent [15:0].
  - Resets to 0.
  - Increments on every transmit_done pulse.
  - Wraps 0xFFFF -> 0x0000.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package serial_32_w_pkg:
  - state enum (IDLE, START, DATA, STOP, GAP).
  - CRC_INIT=16'hFFFF and CRC_POLY=16'hA001.
  - LINE_IDLE=1'b1.
  - Helper function crc16_bit_step(crc, bit).
- One natural sub-module, crc_16_rtu_tx_32_w: bit-serial CRC with clear/enable/bit inputs and a 16-bit output, mirroring the receive-side CRC.
- Everything else stays in one FSM module.

Test Plan:
- Known-CRC frame: N_WORD=3, CLK_PER_BIT=4, data = 0x0103, 0x0000, 0x0001, start pulse.
  - Bytes 01 03 00 00 00 01 84 0A appear on tx.
  - Each byte is 0 + LSB-first + 1; frame length 92 bits = 368 cycles.
  - transmit_done asserts exactly at cycle 368 after busy rises.
- Loopback into serial_receiver_main_32_w: N_WORD=32, data_k = 0x1000+k.
  - receive_done fires; data_0..data_31 = 0x1000..0x101F; errors_count stays 0.
- Start held high for 3 packets: three consecutive frames, each separated by exactly 1 IDLE cycle plus the 12-bit gap; transmit_done pulses 3 times.
- Reset asserted mid-DATA of byte 5: tx=1 and busy=0 asynchronously; next start sends a complete correct frame with CRC re-initialised to 0xFFFF.
- data_in changed from 0xAAAA to 0x5555 while busy: the transmitted bytes remain AA AA (captured values).
- With SERIAL_TX_FRAME_CNT_EN, counter preset near wrap via 65537 short frames (N_WORD=1): frames_sent reads 0x0001 after wrap.
